// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arbiter_pkg;

  localparam int DATA_BUS = 32;
  localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

  // Load/store direction on mem_rw.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Which requester owns the read data returning next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  // True when the byte address is word aligned and inside the RAM.
  function automatic logic addr_ok(input logic [DATA_BUS-1:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[DATA_BUS-1:2]} < words);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and RAM-port signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req/addr/wdata until their gnt.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Instruction fetch port
  logic                if_req;
  logic [DATA_BUS-1:0] if_addr;
  logic                if_gnt;
  logic                if_rvalid;
  logic [DATA_BUS-1:0] if_rdata;

  // Load/store port
  logic                mem_req;
  logic                mem_rw;
  logic [DATA_BUS-1:0] mem_addr;
  logic [DATA_BUS-1:0] mem_wdata;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_BUS-1:0] mem_rdata;

  // Single shared RAM port
  logic                ram_en;
  logic                ram_we;
  logic [DATA_BUS-1:0] ram_addr;
  logic [DATA_BUS-1:0] ram_wdata;
  logic [DATA_BUS-1:0] ram_rdata;

  // Requesters and the RAM itself
  modport master (
    output if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  // The arbiter
  modport slave (
    input  if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port RAM; MEM preferred, IF forced after STREAK_MAX losses.
// Latency: grant is same-cycle combinational; read data returns one cycle after grant.
// Backpressure: loser sees gnt low and must hold its request; bad addresses are granted and read as zero.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned RAM_WORDS  = 4096
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  logic [SW-1:0]       streak;
  owner_e              owner;
  logic                own_zero;
  logic [DATA_BUS-1:0] if_hold;
  logic [DATA_BUS-1:0] mem_hold;
  logic                if_ok;
  logic                mem_ok;
  logic                if_win;
  logic                mem_win;
  logic                mem_wr;
  logic [DATA_BUS-1:0] rd_data;

  // Pick a winner from this cycle's requests; nothing is granted while in reset.
  always_comb begin
    if_ok   = addr_ok(bus.if_addr, RAM_WORDS);
    mem_ok  = addr_ok(bus.mem_addr, RAM_WORDS);
    if_win  = 1'b0;
    mem_win = 1'b0;
    if (!rst) begin
      if (bus.if_req && bus.mem_req) begin
        if (streak == STREAK_TOP) if_win = 1'b1;
        else                      mem_win = 1'b1;
      end else begin
        if_win  = bus.if_req;
        mem_win = bus.mem_req;
      end
    end
  end

  // Steer the granted request onto the RAM port; bad addresses never enable the RAM.
  always_comb begin
    mem_wr        = mem_win && (bus.mem_rw == MEM_WRITE);
    bus.if_gnt    = if_win;
    bus.mem_gnt   = mem_win;
    bus.ram_en    = (if_win && if_ok) || (mem_win && mem_ok);
    bus.ram_we    = mem_wr && mem_ok;
    bus.ram_addr  = if_win ? bus.if_addr : (mem_win ? bus.mem_addr : DATA_ZERO);
    bus.ram_wdata = mem_wr ? bus.mem_wdata : DATA_ZERO;
  end

  // Count consecutive cycles IF lost to MEM; saturates so IF wins the next contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         streak <= '0;
    else if (!bus.if_req || if_win)  streak <= '0;
    else if (mem_win && streak != STREAK_TOP) streak <= streak + 1'b1;
  end

  // Remember who owns next cycle's read data and whether it must read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= OWN_NONE;
      own_zero <= 1'b0;
    end else if (if_win) begin
      owner    <= OWN_IF;
      own_zero <= !if_ok;
    end else if (mem_win && !mem_wr) begin
      owner    <= OWN_MEM;
      own_zero <= !mem_ok;
    end else begin
      owner    <= OWN_NONE;
      own_zero <= 1'b0;
    end
  end

  assign rd_data = own_zero ? DATA_ZERO : bus.ram_rdata;

  // Capture the delivered word so a non-owner's rdata stays put instead of following the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_hold  <= DATA_ZERO;
      mem_hold <= DATA_ZERO;
    end else begin
      if (owner == OWN_IF)  if_hold  <= rd_data;
      if (owner == OWN_MEM) mem_hold <= rd_data;
    end
  end

  // Owner sees live RAM data with rvalid; the other side keeps its last word.
  always_comb begin
    bus.if_rvalid  = (owner == OWN_IF);
    bus.mem_rvalid = (owner == OWN_MEM);
    bus.if_rdata   = bus.if_rvalid  ? rd_data : if_hold;
    bus.mem_rdata  = bus.mem_rvalid ? rd_data : mem_hold;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Latency: checks grants same cycle and read data one cycle later.
// Backpressure: stimulus holds each request until granted.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STREAK_MAX = 4;
  localparam int RAM_WORDS  = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STREAK_MAX(STREAK_MAX), .RAM_WORDS(RAM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM behaviour: synchronous single port, read data one cycle after enable.
  logic [31:0] ram [RAM_WORDS];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr[13:2]] = bus.ram_wdata;
      else            bus.ram_rdata <= ram[bus.ram_addr[13:2]];
    end
  end

  // Reference model state
  logic [31:0] shadow [RAM_WORDS];
  int          m_streak;
  bit          nx_if_rv, nx_mem_rv;
  logic [31:0] nx_if_rd, nx_mem_rd, last_if_rd, last_mem_rd;
  bit          e_if_gnt, e_mem_gnt, e_ram_en, e_ram_we, e_if_rv, e_mem_rv;
  logic [31:0] e_if_rd, e_mem_rd, e_ram_addr;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic bit good(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(RAM_WORDS));
  endfunction

  task automatic model_reset();
    m_streak = 0; nx_if_rv = 0; nx_mem_rv = 0;
    nx_if_rd = '0; nx_mem_rd = '0; last_if_rd = '0; last_mem_rd = '0;
  endtask

  task automatic model_eval();
    e_if_gnt = 0; e_mem_gnt = 0;
    if (!rst) begin
      if (bus.if_req && bus.mem_req) begin
        if (m_streak >= STREAK_MAX) e_if_gnt = 1; else e_mem_gnt = 1;
      end else begin
        e_if_gnt = bus.if_req; e_mem_gnt = bus.mem_req;
      end
    end
    e_ram_en   = (e_if_gnt && good(bus.if_addr)) || (e_mem_gnt && good(bus.mem_addr));
    e_ram_we   = e_mem_gnt && (bus.mem_rw == MEM_WRITE) && good(bus.mem_addr);
    e_ram_addr = e_if_gnt ? bus.if_addr : bus.mem_addr;
    e_if_rv    = nx_if_rv;
    e_mem_rv   = nx_mem_rv;
    e_if_rd    = nx_if_rv  ? nx_if_rd  : last_if_rd;
    e_mem_rd   = nx_mem_rv ? nx_mem_rd : last_mem_rd;
  endtask

  task automatic model_commit();
    if (e_if_rv)  last_if_rd  = nx_if_rd;
    if (e_mem_rv) last_mem_rd = nx_mem_rd;
    nx_if_rv  = e_if_gnt;
    nx_if_rd  = good(bus.if_addr) ? shadow[int'(bus.if_addr[13:2])] : 32'h0;
    nx_mem_rv = e_mem_gnt && (bus.mem_rw == MEM_READ);
    nx_mem_rd = good(bus.mem_addr) ? shadow[int'(bus.mem_addr[13:2])] : 32'h0;
    if (e_ram_we) shadow[int'(bus.mem_addr[13:2])] = bus.mem_wdata;
    if (!bus.if_req || e_if_gnt) m_streak = 0;
    else if (e_mem_gnt && m_streak < STREAK_MAX) m_streak++;
  endtask

  task automatic set_if(input bit req, input logic [31:0] addr);
    bus.if_req = req; bus.if_addr = addr;
  endtask

  task automatic set_mem(input bit req, input bit rw, input logic [31:0] addr, input logic [31:0] wd);
    bus.mem_req = req; bus.mem_rw = rw; bus.mem_addr = addr; bus.mem_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_if(1, 32'h4);
    set_mem(1, MEM_WRITE, 32'h8, 32'h1234);
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 0000", {bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we});
    end
    n_checks++;
    if ({bus.if_rvalid, bus.mem_rvalid} !== 2'b00 || bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd: rv=%b ifd=%h memd=%h want 00/0/0",
                         {bus.if_rvalid, bus.mem_rvalid}, bus.if_rdata, bus.mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    set_if(0, 32'h0);
    set_mem(0, MEM_READ, 32'h0, 32'h0);
    model_reset();
  endtask

  task automatic test_if_burst();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_if(k < 3, 32'(k * 4));
      #1; model_eval();
      if (k < 3) begin
        n_checks++;
        if (bus.if_gnt !== 1'b1 || bus.ram_en !== 1'b1) begin
          n_fail++; $display("FAIL burst_gnt[%0d]: gnt=%b en=%b want 1/1", k, bus.if_gnt, bus.ram_en);
        end
      end
      if (k > 0) begin
        n_checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== ram[k-1]) begin
          n_fail++; $display("FAIL burst_data[%0d]: rv=%b d=%h want 1/%h", k, bus.if_rvalid, bus.if_rdata, ram[k-1]);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_streak();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0 || bus.if_req == 1'b0) set_if(1, 32'($urandom_range(0, 63) * 4));
      set_mem(1, MEM_READ, 32'($urandom_range(0, 63) * 4), 32'h0);
      #1; model_eval();
      n_checks++;
      if ({bus.if_gnt, bus.mem_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL streak[%0d]: if/mem gnt=%b want %b", k, {bus.if_gnt, bus.mem_gnt},
                           (k % 5 == 4) ? 2'b10 : 2'b01);
      end
      model_commit();
      // IF is granted and issues a fresh fetch next cycle; the held one stays otherwise
      if (e_if_gnt) bus.if_req = 1'b0;
    end
    @(negedge clk);
    set_if(0, 32'h0); set_mem(0, MEM_READ, 32'h0, 32'h0);
    #1; model_eval(); model_commit();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_mem(1, MEM_WRITE, 32'h10, 32'hDEADBEEF);
    #1; model_eval();
    n_checks++;
    if (bus.mem_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_grant: gnt=%b we=%b en=%b wd=%h want 1/1/1/deadbeef",
                         bus.mem_gnt, bus.ram_we, bus.ram_en, bus.ram_wdata);
    end
    model_commit();
    @(negedge clk);
    set_mem(1, MEM_READ, 32'h10, 32'h0);
    #1; model_eval();
    n_checks++;
    if (bus.mem_gnt !== 1'b1 || bus.ram_we !== 1'b0 || bus.mem_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_grant: gnt=%b we=%b rv=%b want 1/0/0", bus.mem_gnt, bus.ram_we, bus.mem_rvalid);
    end
    model_commit();
    @(negedge clk);
    set_mem(0, MEM_READ, 32'h0, 32'h0);
    #1; model_eval();
    n_checks++;
    if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== 32'hDEADBEEF || bus.if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_rd_data: rv=%b d=%h ifrv=%b want 1/deadbeef/0",
                         bus.mem_rvalid, bus.mem_rdata, bus.if_rvalid);
    end
    model_commit();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    set_mem(1, MEM_READ, 32'h00004000, 32'h0);
    #1; model_eval();
    n_checks++;
    if (bus.mem_gnt !== 1'b1 || bus.ram_en !== 1'b0) begin
      n_fail++; $display("FAIL oor_grant: gnt=%b en=%b want 1/0", bus.mem_gnt, bus.ram_en);
    end
    model_commit();
    @(negedge clk);
    set_mem(1, MEM_WRITE, 32'h00004010, 32'hFFFF0000);
    #1; model_eval();
    n_checks++;
    if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL oor_data: rv=%b d=%h want 1/0", bus.mem_rvalid, bus.mem_rdata);
    end
    n_checks++;
    if (bus.mem_gnt !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_en !== 1'b0) begin
      n_fail++; $display("FAIL oor_write: gnt=%b we=%b en=%b want 1/0/0", bus.mem_gnt, bus.ram_we, bus.ram_en);
    end
    model_commit();
    @(negedge clk);
    set_mem(0, MEM_READ, 32'h0, 32'h0);
    #1; model_eval();
    n_checks++;
    if (bus.mem_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL oor_wr_norv: rv=%b want 0", bus.mem_rvalid);
    end
    model_commit();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    set_if(1, 32'h2);
    #1; model_eval();
    n_checks++;
    if (bus.if_gnt !== 1'b1 || bus.ram_en !== 1'b0) begin
      n_fail++; $display("FAIL misal_grant: gnt=%b en=%b want 1/0", bus.if_gnt, bus.ram_en);
    end
    model_commit();
    @(negedge clk);
    set_if(0, 32'h0);
    #1; model_eval();
    n_checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0) begin
      n_fail++; $display("FAIL misal_data: rv=%b d=%h want 1/0", bus.if_rvalid, bus.if_rdata);
    end
    model_commit();
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    set_if(1, 32'h8);
    #1; model_eval();
    n_checks++;
    if (bus.if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL inflight_gnt: gnt=%b want 1", bus.if_gnt);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.ram_en, bus.if_rvalid} !== 3'b000) begin
      n_fail++; $display("FAIL inflight_rst: gnt/en/rv=%b want 000", {bus.if_gnt, bus.ram_en, bus.if_rvalid});
    end
    model_reset();
    set_if(0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1; model_eval();
      n_checks++;
      if ({bus.if_rvalid, bus.mem_rvalid, bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we} !== 6'b0 ||
          bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0 || bus.ram_addr !== 32'h0) begin
        n_fail++; $display("FAIL inflight_after[%0d]: ctl=%b ifd=%h memd=%h addr=%h want all 0", k,
                           {bus.if_rvalid, bus.mem_rvalid, bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we},
                           bus.if_rdata, bus.mem_rdata, bus.ram_addr);
      end
      model_commit();
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit          if_pend = 0, mem_pend = 0;
    int          if_wait = 0;
    logic [31:0] a;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) @(negedge clk);
      if (!if_pend) begin
        a = 32'($urandom_range(0, 127) * 4);
        if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? (a | 32'h1) : (a | 32'h8000);
        set_if($urandom_range(0, 3) != 0, a);
      end
      if (!mem_pend) begin
        a = 32'($urandom_range(0, 127) * 4);
        if ($urandom_range(0, 9) == 0) a = a + 32'h4002;
        set_mem($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, a, $urandom);
      end
      #1; model_eval();
      n_checks++;
      if ({bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we} !== {e_if_gnt, e_mem_gnt, e_ram_en, e_ram_we}) begin
        n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", k, {bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we},
                           {e_if_gnt, e_mem_gnt, e_ram_en, e_ram_we});
      end
      if (e_ram_en) begin
        n_checks++;
        if (bus.ram_addr !== e_ram_addr || (e_ram_we && bus.ram_wdata !== bus.mem_wdata)) begin
          n_fail++; $display("FAIL rand_port[%0d]: addr=%h wd=%h want %h/%h", k, bus.ram_addr, bus.ram_wdata,
                             e_ram_addr, bus.mem_wdata);
        end
      end
      n_checks++;
      if ({bus.if_rvalid, bus.mem_rvalid} !== {e_if_rv, e_mem_rv} || bus.if_rdata !== e_if_rd || bus.mem_rdata !== e_mem_rd) begin
        n_fail++; $display("FAIL rand_rd[%0d]: rv=%b ifd=%h memd=%h want %b/%h/%h", k, {bus.if_rvalid, bus.mem_rvalid},
                           bus.if_rdata, bus.mem_rdata, {e_if_rv, e_mem_rv}, e_if_rd, e_mem_rd);
      end
      if (bus.if_req && !e_if_gnt) if_wait++; else if_wait = 0;
      if (if_wait > STREAK_MAX) begin
        n_checks++; n_fail++;
        $display("FAIL rand_starve[%0d]: if waited %0d cycles, limit %0d", k, if_wait, STREAK_MAX);
        if_wait = 0;
      end
      model_commit();
      if_pend  = bus.if_req  && !e_if_gnt;
      mem_pend = bus.mem_req && !e_mem_gnt;
    end
    @(negedge clk);
    set_if(0, 32'h0); set_mem(0, MEM_READ, 32'h0, 32'h0);
    #1; model_eval(); model_commit();
  endtask

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    model_reset();
    test_reset();
    test_if_burst();
    test_streak();
    test_write_read();
    test_out_of_range();
    test_misaligned();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
